// File: rtl/seven_seg_capture.sv
// seven_seg_capture
// Receive side of a multiplexed, active-low seven-segment display bus.
// The 11-bit bus {anode, sevenSeg} is sampled every cycle. A value is
// accepted once it has been seen STABLE_CYCLES times in a row. On acceptance
// the segment pattern is decoded back to a hex nibble and written into the
// register of the digit whose anode is low.
//
// Build option: define SEVEN_SEG_CAPTURE_SYNC_EN to place a two-flop
// synchroniser on all 11 inputs ahead of the sample register. This adds two
// cycles of latency and is meant for asynchronous or off-chip sources.
// Without it, the sample register loads straight from the ports, which suits
// an on-chip synchronous loopback.

module seven_seg_capture #(
    parameter int STABLE_CYCLES = 4    // legal range 2..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] anode,
    input  logic [6:0] sevenSeg,
    output logic [3:0] displayA,
    output logic [3:0] displayB,
    output logic [3:0] displayC,
    output logic [3:0] displayD,
    output logic [3:0] digitValid,
    output logic [3:0] digitUpdate,
    output logic       badPattern
);

    // Bus value seen while every anode is off and every segment is dark.
    localparam logic [10:0] BLANK_BUS = {4'hF, 7'h7F};
    localparam logic [7:0]  CNT_MAX   = 8'(STABLE_CYCLES);

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } captureState_t;

    // Map an active-low segment code back to its nibble. Bit 4 is the
    // "legal code" flag. Any code outside the sixteen glyphs is illegal.
    function automatic logic [4:0] decodeSeg(input logic [6:0] seg);
        logic [4:0] result;
        case (seg)
            7'h40:   result = {1'b1, 4'h0};
            7'h79:   result = {1'b1, 4'h1};
            7'h24:   result = {1'b1, 4'h2};
            7'h30:   result = {1'b1, 4'h3};
            7'h19:   result = {1'b1, 4'h4};
            7'h12:   result = {1'b1, 4'h5};
            7'h02:   result = {1'b1, 4'h6};
            7'h78:   result = {1'b1, 4'h7};
            7'h00:   result = {1'b1, 4'h8};
            7'h10:   result = {1'b1, 4'h9};
            7'h08:   result = {1'b1, 4'hA};
            7'h03:   result = {1'b1, 4'hB};
            7'h46:   result = {1'b1, 4'hC};
            7'h21:   result = {1'b1, 4'hD};
            7'h06:   result = {1'b1, 4'hE};
            7'h0E:   result = {1'b1, 4'hF};
            default: result = 5'b0_0000;
        endcase
        return result;
    endfunction

    logic [10:0]   busIn;
    logic [10:0]   sampleSrc;
    logic [10:0]   smpReg;
    logic [7:0]    cntReg;
    captureState_t stateReg;
    captureState_t stateNext;
    logic          busChanged;
    logic          acceptNow;
    logic [3:0]    smpAnode;
    logic [6:0]    smpSeg;
    logic [3:0]    lowMask;
    logic          oneLow;
    logic          multiLow;
    logic [4:0]    decoded;
    logic [3:0]    writeNext;
    logic          badNext;
    logic          badReg;
    logic [3:0]    displayVal [4];

    assign busIn = {anode, sevenSeg};

`ifdef SEVEN_SEG_CAPTURE_SYNC_EN
    logic [10:0] sync1Reg;
    logic [10:0] sync2Reg;

    // Two-flop synchroniser. It resets to the blank bus so that no spurious
    // window starts when reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1Reg <= BLANK_BUS;
            sync2Reg <= BLANK_BUS;
        end else begin
            sync1Reg <= busIn;
            sync2Reg <= sync1Reg;
        end
    end

    assign sampleSrc = sync2Reg;
`else
    assign sampleSrc = busIn;
`endif

    // An incoming value that differs from the held sample starts a new window.
    assign busChanged = (sampleSrc != smpReg);

    // Sample register and stability counter. The counter saturates at
    // CNT_MAX and restarts at 1 on any change of the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smpReg <= BLANK_BUS;
            cntReg <= 8'd0;
        end else begin
            smpReg <= sampleSrc;
            if (busChanged) begin
                cntReg <= 8'd1;
            end else if (cntReg != CNT_MAX) begin
                cntReg <= cntReg + 8'd1;
            end
        end
    end

    assign smpAnode = smpReg[10:7];
    assign smpSeg   = smpReg[6:0];
    assign lowMask  = ~smpAnode;
    assign decoded  = decodeSeg(smpSeg);

    // Exactly one anode is low when the mask is a non-zero power of two.
    assign oneLow   = (lowMask != 4'd0) && ((lowMask & (lowMask - 4'd1)) == 4'd0);
    assign multiLow = (lowMask != 4'd0) && !oneLow;

    // The accept fires only once per stable window because the FSM leaves
    // SETTLE on the same edge.
    assign acceptNow = (stateReg == SETTLE) && (cntReg == CNT_MAX);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= SETTLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic and accept decision. A bus change at the same edge as
    // an accept still lets the accept complete, but sends the FSM back to
    // SETTLE so that the new value gets its own window.
    always_comb begin
        stateNext = stateReg;
        writeNext = 4'b0000;
        badNext   = 1'b0;
        case (stateReg)
            SETTLE: begin
                if (acceptNow) begin
                    stateNext = LOCKED;
                    if (oneLow) begin
                        if (decoded[4]) begin
                            writeNext = lowMask;
                        end else begin
                            badNext = 1'b1;
                        end
                    end else if (multiLow) begin
                        badNext = 1'b1;
                    end
                end
            end
            LOCKED: begin
                stateNext = LOCKED;
            end
            default: begin
                stateNext = SETTLE;
            end
        endcase
        if (busChanged) begin
            stateNext = SETTLE;
        end
    end

    // Register the bad-pattern flag as a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            badReg <= 1'b0;
        end else begin
            badReg <= badNext;
        end
    end

    assign badPattern = badReg;

    // Per-digit storage. Index gi follows the anode bit numbering:
    // 3 = digit A ... 0 = digit D.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gDigit
            logic [3:0] valueReg;
            logic       validReg;
            logic       updateReg;

            // Capture the decoded nibble and latch the valid bit. The valid
            // bit is cleared only by reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valueReg  <= 4'h0;
                    validReg  <= 1'b0;
                    updateReg <= 1'b0;
                end else begin
                    updateReg <= writeNext[gi];
                    if (writeNext[gi]) begin
                        valueReg <= decoded[3:0];
                        validReg <= 1'b1;
                    end
                end
            end

            assign displayVal[gi]  = valueReg;
            assign digitValid[gi]  = validReg;
            assign digitUpdate[gi] = updateReg;
        end
    endgenerate

    assign displayA = displayVal[3];
    assign displayB = displayVal[2];
    assign displayC = displayVal[1];
    assign displayD = displayVal[0];

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed testbench for seven_seg_capture with STABLE_CYCLES = 4.
// Inputs are driven and outputs are sampled on the falling edge of the clock.
// Pulse counters are updated just after each rising edge.
// Define SEVEN_SEG_CAPTURE_SYNC_EN to build both the bench and the DUT with
// the synchroniser.

module tb_seven_seg_capture;

`ifdef SEVEN_SEG_CAPTURE_SYNC_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] anode = 4'hF;
    logic [6:0] sevenSeg = 7'h7F;
    logic [3:0] displayA, displayB, displayC, displayD;
    logic [3:0] digitValid, digitUpdate;
    logic       badPattern;

    int checks = 0;
    int passes = 0;
    int updCnt [4];
    int badCnt = 0;

    seven_seg_capture #(.STABLE_CYCLES(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .anode(anode),
        .sevenSeg(sevenSeg),
        .displayA(displayA),
        .displayB(displayB),
        .displayC(displayC),
        .displayD(displayD),
        .digitValid(digitValid),
        .digitUpdate(digitUpdate),
        .badPattern(badPattern)
    );

    always #5 clk = ~clk;

    // Count cycles in which each pulse output is high. A pulse that lasts
    // two cycles is therefore counted twice.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (digitUpdate[i]) updCnt[i]++;
        end
        if (badPattern) badCnt++;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic waitN(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s);
        @(negedge clk);
        anode    = a;
        sevenSeg = s;
        $display("t=%0t drive anode=%b seg=%h", $time, a, s);
    endtask

    function automatic int updTotal();
        return updCnt[0] + updCnt[1] + updCnt[2] + updCnt[3];
    endfunction

    logic [3:0] tAnode [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [6:0] tSeg   [4] = '{7'h08, 7'h79, 7'h21, 7'h10};

    initial begin
        int u0, b0;
        int ub [4];
        for (int i = 0; i < 4; i++) updCnt[i] = 0;

        // Reset, then hold the blank bus.
        #2 rst_n = 1'b0;
        waitN(3);
        checkVal("rst_dispA", 32'(displayA), 32'h0);
        checkVal("rst_valid", 32'(digitValid), 32'h0);
        checkVal("rst_update", 32'(digitUpdate), 32'h0);
        checkVal("rst_bad", 32'(badPattern), 32'h0);
        rst_n = 1'b1;
        waitN(20);
        checkVal("blank_upd", 32'(updTotal()), 32'd0);
        checkVal("blank_bad", 32'(badCnt), 32'd0);
        checkVal("blank_valid", 32'(digitValid), 32'h0);
        checkVal("blank_dispD", 32'(displayD), 32'h0);
        $display("t=%0t reset/blank done", $time);

        // Single digit A = 3, with exact pulse timing.
        u0 = updTotal();
        drive(4'b0111, 7'h30);
        waitN(LAT);
        checkVal("a3_pre_upd", 32'(digitUpdate), 32'h0);
        waitN(1);
        checkVal("a3_upd", 32'(digitUpdate), 32'h8);
        checkVal("a3_dispA", 32'(displayA), 32'h3);
        checkVal("a3_valid", 32'(digitValid), 32'h8);
        waitN(1);
        checkVal("a3_post_upd", 32'(digitUpdate), 32'h0);
        waitN(50);
        checkVal("a3_one_pulse", 32'(updTotal() - u0), 32'd1);

        // "A1d9" shown twice, six cycles per digit.
        for (int i = 0; i < 4; i++) ub[i] = updCnt[i];
        for (int p = 0; p < 2; p++) begin
            for (int d = 0; d < 4; d++) begin
                drive(tAnode[d], tSeg[d]);
                waitN(5);
            end
        end
        waitN(10);
        checkVal("scan_dispA", 32'(displayA), 32'hA);
        checkVal("scan_dispB", 32'(displayB), 32'h1);
        checkVal("scan_dispC", 32'(displayC), 32'hD);
        checkVal("scan_dispD", 32'(displayD), 32'h9);
        checkVal("scan_valid", 32'(digitValid), 32'hF);
        checkVal("scan_updA", 32'(updCnt[3] - ub[3]), 32'd2);
        checkVal("scan_updB", 32'(updCnt[2] - ub[2]), 32'd2);
        checkVal("scan_updC", 32'(updCnt[1] - ub[1]), 32'd2);
        checkVal("scan_updD", 32'(updCnt[0] - ub[0]), 32'd2);

        // Illegal segment code on digit C.
        b0 = badCnt;
        u0 = updTotal();
        drive(4'b1101, 7'h7E);
        waitN(LAT + 4);
        checkVal("badseg_pulse", 32'(badCnt - b0), 32'd1);
        checkVal("badseg_dispC", 32'(displayC), 32'hD);
        checkVal("badseg_noupd", 32'(updTotal() - u0), 32'd0);

        // Two anodes low at once.
        b0 = badCnt;
        drive(4'b0011, 7'h40);
        waitN(LAT + 4);
        checkVal("badan_pulse", 32'(badCnt - b0), 32'd1);
        checkVal("badan_noupd", 32'(updTotal() - u0), 32'd0);
        checkVal("badan_dispA", 32'(displayA), 32'hA);
        checkVal("badan_dispB", 32'(displayB), 32'h1);

        // Glitch in the middle of a window on digit D.
        u0 = updCnt[0];
        b0 = badCnt;
        drive(4'b1110, 7'h00);
        waitN(1);
        drive(4'b1110, 7'h79);
        waitN(1);
        drive(4'b1110, 7'h00);
        waitN(LAT);
        checkVal("glitch_noacc", 32'(updCnt[0] - u0), 32'd0);
        checkVal("glitch_pre_upd", 32'(digitUpdate), 32'h0);
        waitN(1);
        checkVal("glitch_upd", 32'(digitUpdate), 32'h1);
        checkVal("glitch_dispD", 32'(displayD), 32'h8);
        checkVal("glitch_nobad", 32'(badCnt - b0), 32'd0);

        // Reset in the middle of a window, then a fresh full window.
        drive(4'b1011, 7'h12);
        waitN(1);
        rst_n = 1'b0;
        #1;
        checkVal("mrst_dispD", 32'(displayD), 32'h0);
        checkVal("mrst_valid", 32'(digitValid), 32'h0);
        waitN(2);
        rst_n = 1'b1;
        $display("t=%0t reset released", $time);
        waitN(LAT);
        checkVal("mrst_pre_upd", 32'(digitUpdate), 32'h0);
        checkVal("mrst_pre_valid", 32'(digitValid), 32'h0);
        waitN(1);
        checkVal("mrst_upd", 32'(digitUpdate), 32'h4);
        checkVal("mrst_dispB", 32'(displayB), 32'h5);
        checkVal("mrst_valid2", 32'(digitValid), 32'h4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
